// File: rtl/adder_result_buffer.sv
// Show-ahead FIFO that buffers {cout, sum} results from a ripple-carry adder and
// tracks carry status. Optional saturating overflow counter under ADDER_OVF_COUNT_EN.
module adder_result_buffer #(
  parameter int PROC_SIZE = 16,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [PROC_SIZE-1:0]     in_sum,
  input  logic                     in_cout,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PROC_SIZE:0]       out_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clear_status,
  output logic                     carry_seen,
  output logic [7:0]               ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = PROC_SIZE + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t        state_reg, state_next;
  logic          run_reg;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [DW-1:0] out_data_reg, head_next;
  logic          carry_reg, carry_next;
  logic          push, pop;
  logic [DW-1:0] in_entry;

  // Handshake flags come straight from registers; run_reg keeps in_ready low
  // until the first clock edge after reset is released.
  assign in_ready  = run_reg && (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = out_data_reg;
  assign count     = count_reg;
  assign carry_seen = carry_reg;

  assign in_entry = {in_cout, in_sum};
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end

    wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    if (count_next == '0) begin
      state_next = EMPTY;
    end else if (count_next == FULL_CNT) begin
      state_next = FULL;
    end else begin
      state_next = PARTIAL;
    end
  end

  // Next head: if no older entry survives this cycle, the new head is the one
  // being written now, so bypass the array; otherwise read the next slot.
  always_comb begin
    head_next = out_data_reg;
    if (count_next != '0) begin
      if (count_reg == CW'(pop)) begin
        head_next = in_entry;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_comb begin
    carry_next = carry_reg;
    if (push && in_cout) begin
      carry_next = 1'b1;
    end else if (clear_status) begin
      carry_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      run_reg      <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
      carry_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_reg      <= 1'b1;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      out_data_reg <= head_next;
      carry_reg    <= carry_next;
    end
  end

`ifdef ADDER_OVF_COUNT_EN
  logic [7:0] ovf_reg, ovf_next;

  // Clear takes priority over a same-cycle increment; saturates at 255.
  always_comb begin
    ovf_next = ovf_reg;
    if (clear_status) begin
      ovf_next = '0;
    end else if (push && in_cout && (ovf_reg != 8'hFF)) begin
      ovf_next = ovf_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= '0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf_cnt = ovf_reg;
`else
  assign ovf_cnt = '0;
`endif

endmodule
